// File: rtl/altro_emu_pkg.sv
// altro_emu_pkg: shared command codes, register map, trailer fields and FSM states
package altro_emu_pkg;
   localparam logic [4:0] CMD_CHRDO = 5'h1A;
   localparam logic [4:0] REG_TRCFG = 5'h0A;
   localparam logic [4:0] REG_WCNT = 5'h0B;
   localparam logic [4:0] REG_CHMASK = 5'h0C;
   localparam logic [13:0] TRL_MARK = 14'h2AAA;
   localparam logic [3:0] TRL_NIB = 4'hA;
   localparam logic [39:0] ERR_PAT = 40'h0055005500;
   typedef enum logic [3:0] {
      IDLE, DECODE, IGNORE, WR_ACK, WR_HOLD, RD_DRV,
      RDO_ACK, RDO_WAIT, RDO_GAP, RDO_TRSF, RDO_DATA, RDO_TRL
   } state_t;
   function automatic logic [39:0] trailer(input logic [7:0] w, input logic [11:0] ch_addr);
      return {TRL_MARK, {w, 2'b00}, TRL_NIB, ch_addr};
   endfunction
endpackage

// File: rtl/altro_emu_pattern.sv
// altro_emu_pattern: payload word i of channel ch, four 10-bit ramp samples packed low-first
module altro_emu_pattern (
   input  logic [3:0]  ch,
   input  logic [7:0]  idx,
   output logic [39:0] word
);
   logic [9:0] base;
   assign base = {ch, 6'b0} + {idx, 2'b00} + 10'd1;
   assign word = {base + 10'd3, base + 10'd2, base + 10'd1, base};
endmodule

// File: rtl/altro_chip_emulator.sv
// altro_chip_emulator: ALTRO bus slave with register file and channel readout emulation
module altro_chip_emulator
   import altro_emu_pkg::*;
#(
   parameter int N_CH = 16,
   parameter int DEF_WORDS = 7,
   parameter int GAP = 4,
   parameter logic [7:0] BOARD_ADDR = 8'h00
) (
   input  logic rdoclk,
   input  logic reset_n,
   input  logic cstbn,
   input  logic writen,
   output logic ackn,
   output logic trsfn,
   output logic dstbn,
   inout  wire  [39:0] bd
);
   state_t state_q, state_d;
   logic [7:0] cnt, wcnt, w, pidx;
   logic [4:0] cmd_q;
   logic bcast_q, bd_oe, de, ign, bd_unused;
   logic [11:0] ch_addr;
   logic [19:0] gen [8];
   logic [9:0] trcfg;
   logic [15:0] chmask;
   logic [39:0] bd_q, rd_data, pat_word;

   assign bd = bd_oe ? bd_q : 'z;
   assign dstbn = de ? rdoclk : 1'b1;
   assign bd_unused = ^{bd[39], bd[37]};
   assign ign = bd[38] ? (writen || bd[24:20] == CMD_CHRDO) : bd[36:29] != BOARD_ADDR;
   assign w = (int'(ch_addr[3:0]) < N_CH && chmask[ch_addr[3:0]]) ? wcnt : 8'd0;
   assign pidx = state_q == RDO_DATA ? cnt + 8'd1 : 8'd0;
   assign rd_data = cmd_q[4:3] == 2'b00 ? {20'b0, gen[cmd_q[2:0]]} :
                    cmd_q == REG_TRCFG ? {30'b0, trcfg} :
                    cmd_q == REG_WCNT ? {32'b0, wcnt} :
                    cmd_q == REG_CHMASK ? {24'b0, chmask} : ERR_PAT;

   altro_emu_pattern u_pat (.ch(ch_addr[3:0]), .idx(pidx), .word(pat_word));

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     state_d = cstbn ? IDLE : DECODE;
         DECODE:   state_d = ign ? IGNORE : bd[24:20] == CMD_CHRDO ? RDO_ACK : writen ? RD_DRV : WR_ACK;
         IGNORE:   state_d = cstbn ? IDLE : IGNORE;
         WR_ACK:   state_d = WR_HOLD;
         WR_HOLD:  state_d = cstbn ? IDLE : WR_HOLD;
         RD_DRV:   state_d = cnt == 8'd3 ? IDLE : RD_DRV;
         RDO_ACK:  state_d = RDO_WAIT;
         RDO_WAIT: state_d = cstbn ? RDO_GAP : RDO_WAIT;
         RDO_GAP:  state_d = cnt == 8'(GAP - 1) ? RDO_TRSF : RDO_GAP;
         RDO_TRSF: state_d = w == 8'd0 ? RDO_TRL : RDO_DATA;
         RDO_DATA: state_d = cnt == w - 8'd1 ? RDO_TRL : RDO_DATA;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge rdoclk or negedge reset_n)
      if (!reset_n) state_q <= IDLE;
      else state_q <= state_d;

   // cnt restarts on every state change; RD_DRV spends its first cycle before the bus turns around
   always_ff @(posedge rdoclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         cmd_q <= '0;
         bcast_q <= 1'b0;
         ch_addr <= '0;
         for (int i = 0; i < 8; i++) gen[i] <= '0;
         trcfg <= '0;
         wcnt <= 8'(DEF_WORDS);
         chmask <= 16'hFFFF;
         ackn <= 1'b1;
         trsfn <= 1'b1;
         bd_oe <= 1'b0;
         de <= 1'b0;
         bd_q <= '0;
      end else begin
         cnt <= state_d != state_q ? 8'd0 : cnt + 8'd1;
         if (state_q == DECODE) begin
            cmd_q <= bd[24:20];
            bcast_q <= bd[38];
         end
         if (state_q == RDO_ACK) ch_addr <= bd[36:25];
         if (state_q == WR_ACK) begin
            if (cmd_q[4:3] == 2'b00) gen[cmd_q[2:0]] <= bd[19:0];
            if (cmd_q == REG_TRCFG) trcfg <= bd[9:0];
            if (cmd_q == REG_WCNT) wcnt <= bd[7:0];
            if (cmd_q == REG_CHMASK) chmask <= bd[15:0];
         end
         ackn <= !((state_d == WR_HOLD && !bcast_q) || (state_q == RD_DRV && state_d == RD_DRV) || state_d == RDO_WAIT);
         trsfn <= !(state_d == RDO_TRSF || state_d == RDO_DATA || state_d == RDO_TRL);
         bd_oe <= (state_q == RD_DRV && state_d == RD_DRV) || state_d == RDO_DATA || state_d == RDO_TRL;
         de <= state_d == RDO_DATA || state_d == RDO_TRL;
         bd_q <= state_d == RDO_TRL ? trailer(w, ch_addr) : state_d == RDO_DATA ? pat_word : rd_data;
      end
   end
endmodule
